// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the memory bus arbiter: FSM states, owner encoding, widths.
// No logic; imported by mem_arb_port and mem_bus_arbiter.
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } arb_state_e;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DMA = 1'b1;

endpackage

// File: rtl/mem_arb_port.sv
// Per-requester return path: read-data capture register and one-cycle ack; both settle one cycle after DATA.
// No backpressure; ack is a pulse the requester must observe while it holds req.
module mem_arb_port
    import mem_arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              data_sel,
    input  logic              write,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              ack,
    output logic [DATA_W-1:0] rdata
);

    logic              ack_q, ack_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    // Registering on the DATA phase makes ack and rdata land together in DONE.
    always_comb begin
        ack_d   = data_sel;
        rdata_d = rdata_q;
        if (data_sel && !write) begin
            rdata_d = mem_rdata;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            ack_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
        end
    end

    assign ack   = ack_q;
    assign rdata = rdata_q;

endmodule

// File: rtl/mem_bus_arbiter.sv
// CPU/DMA round-robin arbiter for the 8-bit memory bus; req->ack 3 cycles, requesters hold req until ack.
// MEM_ARB_LOCK_EN adds cpu_lock/dma_lock: owner keeps the bus from DONE straight into ADDR.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              Clk,
    input  logic              Reset,
`ifdef MEM_ARB_LOCK_EN
    input  logic              cpu_lock,
    input  logic              dma_lock,
`endif
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_write,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dma_req,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    input  logic              dma_write,
    output logic              dma_ack,
    output logic [DATA_W-1:0] dma_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              owner,
    output logic              busy
);

    arb_state_e state_q, state_d;
    logic       owner_q, owner_d;
    logic       own_write;
    logic       cpu_data_sel;
    logic       dma_data_sel;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        case (state_q)
            IDLE: begin
                if (cpu_req || dma_req) begin
                    state_d = ADDR;
                    // Under contention the port that did not hold the bus last wins.
                    if (cpu_req && dma_req) begin
                        owner_d = ~owner_q;
                    end else begin
                        owner_d = dma_req ? OWN_DMA : OWN_CPU;
                    end
                end
            end
            ADDR: state_d = DATA;
            DATA: state_d = DONE;
            DONE: begin
                state_d = IDLE;
`ifdef MEM_ARB_LOCK_EN
                if ((owner_q == OWN_DMA) ? dma_lock : cpu_lock) begin
                    state_d = ADDR;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            owner_q <= OWN_DMA;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

    // Bus is driven only in ADDR/DATA; the strobe follows state_q so reset drops it at once.
    always_comb begin
        own_write = (owner_q == OWN_DMA) ? dma_write : cpu_write;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_write = 1'b0;
        if (state_q == ADDR || state_q == DATA) begin
            mem_addr  = (owner_q == OWN_DMA) ? dma_addr  : cpu_addr;
            mem_wdata = (owner_q == OWN_DMA) ? dma_wdata : cpu_wdata;
        end
        if (state_q == ADDR) begin
            mem_write = own_write;
        end
    end

    assign cpu_data_sel = (state_q == DATA) && (owner_q == OWN_CPU);
    assign dma_data_sel = (state_q == DATA) && (owner_q == OWN_DMA);
    assign owner        = owner_q;
    assign busy         = (state_q != IDLE);

    mem_arb_port #(.DATA_W(DATA_W)) u_cpu_port (
        .Clk       (Clk),
        .Reset     (Reset),
        .data_sel  (cpu_data_sel),
        .write     (cpu_write),
        .mem_rdata (mem_rdata),
        .ack       (cpu_ack),
        .rdata     (cpu_rdata)
    );

    mem_arb_port #(.DATA_W(DATA_W)) u_dma_port (
        .Clk       (Clk),
        .Reset     (Reset),
        .data_sel  (dma_data_sel),
        .write     (dma_write),
        .mem_rdata (mem_rdata),
        .ack       (dma_ack),
        .rdata     (dma_rdata)
    );

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboarded bench for mem_bus_arbiter: drivers push expected responses, a negedge monitor pops on ack.
// Memory is a behavioural 256-byte RAM with one-cycle read latency; a shadow array predicts read data.
module tb_mem_bus_arbiter;

    logic       Clk   = 1'b0;
    logic       Reset = 1'b1;
    logic       cpu_req = 1'b0, cpu_write = 1'b0, dma_req = 1'b0, dma_write = 1'b0;
    logic [7:0] cpu_addr = '0, cpu_wdata = '0, dma_addr = '0, dma_wdata = '0;
    logic       cpu_ack, dma_ack, mem_write, owner, busy;
    logic [7:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata;
    logic [7:0] mem_rdata = '0;
`ifdef MEM_ARB_LOCK_EN
    logic       cpu_lock = 1'b0, dma_lock = 1'b0;
`endif

    mem_bus_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
`ifdef MEM_ARB_LOCK_EN
        .cpu_lock  (cpu_lock),
        .dma_lock  (dma_lock),
`endif
        .cpu_req   (cpu_req),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_write (cpu_write),
        .cpu_ack   (cpu_ack),
        .cpu_rdata (cpu_rdata),
        .dma_req   (dma_req),
        .dma_addr  (dma_addr),
        .dma_wdata (dma_wdata),
        .dma_write (dma_write),
        .dma_ack   (dma_ack),
        .dma_rdata (dma_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_write (mem_write),
        .mem_rdata (mem_rdata),
        .owner     (owner),
        .busy      (busy)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [7:0] rdata;
        int         issue;
        int         lo;
        int         hi;
    } exp_t;

    exp_t       cpu_q[$];
    exp_t       dma_q[$];
    logic [7:0] shadow [256];
    logic [7:0] ram [256];
    logic [7:0] last_rd [2];
    int         vectors = 0, miscompares = 0, cyc = 0;
    int         exp_writes = 0, seen_writes = 0;
    bit         mem_init = 1'b0;

    function automatic logic [7:0] init_val(input int i);
        if (i == 16) return 8'h86;
        return 8'(i * 37 + 11);
    endfunction

    always @(posedge Clk) cyc++;

    always @(posedge Clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 256; i++) ram[i] <= init_val(i);
            mem_init <= 1'b1;
        end else if (mem_write) begin
            ram[mem_addr] <= mem_wdata;
        end
        mem_rdata <= ram[mem_addr];
    end

    task automatic check(input string name, input int act, input int want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, want);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        vectors++;
        if (act < lo || act > hi) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic mon_port(input bit p);
        exp_t e;
        if ((p && dma_q.size() == 0) || (!p && cpu_q.size() == 0)) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_ack port %0d: got ack, expected none", p);
            return;
        end
        if (p) e = dma_q.pop_front();
        else   e = cpu_q.pop_front();
        check(p ? "dma_rdata" : "cpu_rdata", p ? dma_rdata : cpu_rdata, e.rdata);
        check("ack_owner", owner, p);
        check_range("ack_latency", cyc - e.issue, e.lo, e.hi);
    endtask

    always @(negedge Clk) begin
        if (mem_write) seen_writes++;
        if (cpu_ack) mon_port(1'b0);
        if (dma_ack) mon_port(1'b1);
    end

    // Issues one access, records its expected response, waits (bounded) for the ack.
    task automatic access(input bit p, input logic [7:0] a, input logic [7:0] wd, input bit wr,
                          input int lo, input int hi, input bit keep);
        exp_t e;
        bit   got = 1'b0;
        if (p) begin dma_addr = a; dma_wdata = wd; dma_write = wr; dma_req = 1'b1; end
        else   begin cpu_addr = a; cpu_wdata = wd; cpu_write = wr; cpu_req = 1'b1; end
        e.issue = cyc;
        e.lo    = lo;
        e.hi    = hi;
        if (wr) begin
            shadow[a] = wd;
            exp_writes++;
            e.rdata = last_rd[p];
        end else begin
            e.rdata    = shadow[a];
            last_rd[p] = shadow[a];
        end
        if (p) dma_q.push_back(e);
        else   cpu_q.push_back(e);
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge Clk); #1;
            got = p ? dma_ack : cpu_ack;
        end
        if (!got) begin
            vectors++;
            miscompares++;
            $display("FAIL ack_timeout port %0d: got no ack, expected one within 20 cycles", p);
        end
        if (!keep) begin
            if (p) dma_req = 1'b0;
            else   cpu_req = 1'b0;
        end
    endtask

    task automatic drive_rand(input bit p);
        logic [7:0] a;
        logic [7:0] wd;
        bit         wr;
        int         nxt;
        for (int i = 0; i < 40; i++) begin
            a   = {p, 7'($urandom_range(0, 127))};
            wd  = 8'($urandom);
            wr  = 1'($urandom_range(0, 1));
            nxt = $urandom_range(0, 3);
            access(p, a, wd, wr, 3, 8, (nxt == 0 && i < 39));
            repeat (nxt) begin @(posedge Clk); #1; end
        end
    endtask

    task automatic tick();
        @(posedge Clk); #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish, expected finish before 400000");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) shadow[i] = init_val(i);
        last_rd[0] = '0;
        last_rd[1] = '0;
        #2 Reset = 1'b0;
        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_owner", owner, 1);
        check("rst_acks", {cpu_ack, dma_ack}, 0);
        check("rst_rdata", {cpu_rdata, dma_rdata}, 0);
        check("rst_mem", {mem_addr, mem_wdata, mem_write}, 0);
        Reset = 1'b1;
        tick();

        // Contention from reset: CPU, DMA, CPU with acks 4 cycles apart.
        fork
            begin
                access(1'b0, 8'h05, 8'h00, 1'b0, 3, 3, 1'b1);
                access(1'b0, 8'h06, 8'hC3, 1'b1, 8, 8, 1'b0);
            end
            access(1'b1, 8'h90, 8'h00, 1'b0, 7, 7, 1'b0);
        join
        tick();

        // CPU read of 0x10.
        fork
            access(1'b0, 8'h10, 8'h00, 1'b0, 3, 3, 1'b0);
            begin
                tick();
                check("rd_addr_phase_addr", mem_addr, 8'h10);
                check("rd_addr_phase_we", mem_write, 0);
                check("rd_busy", busy, 1);
                tick();
                check("rd_data_phase_addr", mem_addr, 8'h10);
                check("rd_data_phase_we", mem_write, 0);
                tick();
                check("rd_done_addr", mem_addr, 0);
            end
        join
        check("rd_value", cpu_rdata, 8'h86);
        tick();

        // DMA write of 0x5A to 0x40.
        fork
            access(1'b1, 8'h40, 8'h5A, 1'b1, 3, 3, 1'b0);
            begin
                tick();
                check("wr_addr_phase_we", mem_write, 1);
                check("wr_addr_phase_bus", {mem_addr, mem_wdata}, 16'h405A);
                check("wr_owner", owner, 1);
                tick();
                check("wr_data_phase_we", mem_write, 0);
                tick();
                check("wr_done_we", mem_write, 0);
            end
        join
        tick();
        check("wr_ram", ram[64], 8'h5A);

        // Reset during DATA of a CPU read.
        cpu_addr = 8'h22; cpu_write = 1'b0; cpu_req = 1'b1;
        tick();
        tick();
        check("rst_mid_busy_before", busy, 1);
        Reset = 1'b0; cpu_req = 1'b0;
        last_rd[0] = '0;
        last_rd[1] = '0;
        #1;
        check("rst_mid_async_busy", busy, 0);
        check("rst_mid_async_mem", {mem_addr, mem_wdata, mem_write}, 0);
        check("rst_mid_async_rdata", {cpu_rdata, dma_rdata}, 0);
        check("rst_mid_owner", owner, 1);
        tick();
        check("rst_mid_no_ack", {cpu_ack, dma_ack}, 0);
        Reset = 1'b1;
        tick();
        access(1'b0, 8'h10, 8'h00, 1'b0, 3, 3, 1'b0);
        repeat (2) tick();

        fork
            drive_rand(1'b0);
            drive_rand(1'b1);
        join
        repeat (2) tick();

`ifdef MEM_ARB_LOCK_EN
        // Locked CPU burst holds off a waiting DMA request.
        fork
            begin
                cpu_lock = 1'b1;
                access(1'b0, 8'h11, 8'h00, 1'b0, 3, 3, 1'b1);
                access(1'b0, 8'h12, 8'h77, 1'b1, 3, 3, 1'b1);
                access(1'b0, 8'h13, 8'h00, 1'b0, 3, 3, 1'b0);
                cpu_lock = 1'b0;
            end
            begin
                tick();
                access(1'b1, 8'h91, 8'h00, 1'b0, 12, 12, 1'b0);
            end
        join
        repeat (2) tick();
`endif

        check("cpu_q_drained", cpu_q.size(), 0);
        check("dma_q_drained", dma_q.size(), 0);
        check("write_strobes", seen_writes, exp_writes);
        for (int i = 0; i < 256; i++) check("ram_contents", ram[i], shadow[i]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
